// File: rtl/sp_lane_align_ctrl_if.sv
// Byte stream and status bundle between the serial-to-parallel converter and
// the lane alignment controller.
interface sp_lane_align_ctrl_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       active;
  logic       sync_lost;
  logic [1:0] state;
  logic [7:0] loss_count;

  // Byte source side: drives raw bytes, observes forwarded payload and status.
  modport master (
    output in_data,
    output in_valid,
    input  out_data,
    input  out_valid,
    input  active,
    input  sync_lost,
    input  state,
    input  loss_count
  );

  // Alignment controller side.
  modport slave (
    input  in_data,
    input  in_valid,
    output out_data,
    output out_valid,
    output active,
    output sync_lost,
    output state,
    output loss_count
  );
endinterface

// File: rtl/sp_lane_align_ctrl.sv
// Byte-level lane alignment controller: locks on a run of COM symbols, forwards
// payload while locked, strips COM/IDL. Define SP_ALIGN_STATS_EN for the loss counter.
module sp_lane_align_ctrl #(
  parameter logic [7:0]  COM_BYTE   = 8'hBC,
  parameter logic [7:0]  IDL_BYTE   = 8'h7C,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned MAX_GAP    = 16
) (
  input logic                 clk4f,
  input logic                 reset,
  sp_lane_align_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StReset  = 2'b00,
    StSearch = 2'b01,
    StActive = 2'b10
  } state_e;

  localparam logic [3:0] LockLast = 4'(LOCK_COUNT - 1);
  localparam logic [7:0] GapLast  = 8'(MAX_GAP - 1);

  state_e     state_q, state_d;
  logic [3:0] com_cnt_q, com_cnt_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       sync_lost_q, sync_lost_d;

  logic is_com;
  logic is_idl;

  assign is_com = (bus.in_data == COM_BYTE);
  assign is_idl = (bus.in_data == IDL_BYTE);

  always_comb begin
    state_d     = state_q;
    com_cnt_d   = com_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    sync_lost_d = 1'b0;

    unique case (state_q)
      StReset: begin
        state_d   = StSearch;
        com_cnt_d = '0;
        gap_cnt_d = '0;
      end

      StSearch: begin
        if (bus.in_valid) begin
          if (is_com) begin
            if (com_cnt_q >= LockLast) begin
              state_d   = StActive;
              com_cnt_d = '0;
              gap_cnt_d = '0;
            end else begin
              com_cnt_d = com_cnt_q + 4'd1;
            end
          end else begin
            com_cnt_d = '0;
          end
        end
      end

      StActive: begin
        if (bus.in_valid) begin
          if (is_com) begin
            gap_cnt_d = '0;
          end else if (gap_cnt_q >= GapLast) begin
            // Check precedes the increment so gap_cnt never reaches MAX_GAP or wraps.
            state_d     = StSearch;
            com_cnt_d   = '0;
            gap_cnt_d   = '0;
            sync_lost_d = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q + 8'd1;
            if (!is_idl) begin
              out_data_d  = bus.in_data;
              out_valid_d = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = StReset;
      end
    endcase
  end

  always_ff @(posedge clk4f) begin
    if (reset) begin
      state_q     <= StReset;
      com_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      sync_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      com_cnt_q   <= com_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sync_lost_q <= sync_lost_d;
    end
  end

`ifdef SP_ALIGN_STATS_EN
  logic [7:0] loss_count_q;

  always_ff @(posedge clk4f) begin
    if (reset) begin
      loss_count_q <= 8'h00;
    end else if (sync_lost_d && (loss_count_q != 8'hFF)) begin
      loss_count_q <= loss_count_q + 8'd1;
    end
  end

  assign bus.loss_count = loss_count_q;
`else
  assign bus.loss_count = 8'h00;
`endif

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sync_lost = sync_lost_q;
  assign bus.state     = state_q;
  assign bus.active    = (state_q == StActive);

endmodule
